// File: rtl/spi_fifo_bridge_if.sv
// Host and SPI-master handshake bundle for spi_fifo_bridge.
// The bridge uses the slave view; the host/master side uses master.
interface spi_fifo_bridge_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  wr_valid;
   logic                  wr_ready;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  m_start;
   logic                  m_txe;
   logic [DATA_WIDTH-1:0] m_tx_data;
   logic                  m_busy;
   logic                  m_done;
   logic [DATA_WIDTH-1:0] m_rx_data;

   modport slave (
      input  wr_valid, wr_data, rd_ready,
      input  m_busy, m_done, m_rx_data,
      output wr_ready, rd_valid, rd_data,
      output m_start, m_txe, m_tx_data
   );

   modport master (
      output wr_valid, wr_data, rd_ready,
      output m_busy, m_done, m_rx_data,
      input  wr_ready, rd_valid, rd_data,
      input  m_start, m_txe, m_tx_data
   );
endinterface

// File: rtl/spi_fifo_bridge.sv
// TX/RX word FIFOs in front of an SPI master, with a small sequencer
// that chains queued words into one chip-select burst.
module spi_fifo_bridge #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   spi_fifo_bridge_if.slave        bus,
   input  logic                    flush,
   input  logic                    clr_overflow,
   output logic [$clog2(DEPTH):0]  tx_level,
   output logic [$clog2(DEPTH):0]  rx_level,
   output logic                    rx_overflow
);
   localparam int AW = $clog2(DEPTH);

   typedef logic [AW:0]   ptr_t;
   typedef logic [AW-1:0] idx_t;
   typedef enum logic [1:0] {IDLE, START, ACTIVE, HANDOFF} state_t;

   logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];

   ptr_t   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   ptr_t   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   state_t state_q;
   logic   start_q;
   logic   ovf_q, ovf_d;

   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_push, tx_pop, rx_push, rx_pop, rx_done;
   idx_t rx_widx;

   assign tx_empty = tx_wr_q == tx_rd_q;
   assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) &&
                     (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
   assign rx_empty = rx_wr_q == rx_rd_q;
   assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) &&
                     (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

   assign tx_level = tx_wr_q - tx_rd_q;
   assign rx_level = rx_wr_q - rx_rd_q;

   // The master latches the head in START, and in HANDOFF when it continues.
   assign tx_pop = !tx_empty &&
                   ((state_q == START) || (state_q == HANDOFF && !rx_full));

   // A full TX FIFO still takes a word on the cycle it is popped.
   assign bus.wr_ready = (!tx_full || tx_pop) && !flush;
   assign tx_push      = bus.wr_valid && bus.wr_ready;

   assign bus.m_start   = start_q;
   assign bus.m_txe     = tx_empty | rx_full;
   assign bus.m_tx_data = tx_mem_q[tx_rd_q[AW-1:0]];

   assign bus.rd_valid = !rx_empty;
   assign bus.rd_data  = rx_empty ? '0 : rx_mem_q[rx_rd_q[AW-1:0]];
   assign rx_pop       = !rx_empty && bus.rd_ready;

   // A word finishing during flush survives as the only RX entry.
   assign rx_done = (state_q == ACTIVE) && bus.m_done;
   assign rx_push = rx_done && (!rx_full || rx_pop || flush);
   assign rx_widx = flush ? '0 : rx_wr_q[AW-1:0];

   assign rx_overflow = ovf_q;

   // Next-state pointers and sticky overflow flag.
   always_comb begin
      tx_wr_d = flush ? '0 : tx_wr_q + {{AW{1'b0}}, tx_push};
      tx_rd_d = flush ? '0 : tx_rd_q + {{AW{1'b0}}, tx_pop};
      rx_wr_d = flush ? {{AW{1'b0}}, rx_push}
                      : rx_wr_q + {{AW{1'b0}}, rx_push};
      rx_rd_d = flush ? '0 : rx_rd_q + {{AW{1'b0}}, rx_pop};
      ovf_d   = ovf_q;
      if (clr_overflow)
         ovf_d = 1'b0;
      if (rx_done && !rx_push)
         ovf_d = 1'b1;
   end

   // FIFO storage; contents need no reset since pointers gate them.
   always_ff @(posedge clk) begin
      if (tx_push)
         tx_mem_q[tx_wr_q[AW-1:0]] <= bus.wr_data;
      if (rx_push)
         rx_mem_q[rx_widx] <= bus.m_rx_data;
   end

   // Pointer and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wr_q <= '0;
         tx_rd_q <= '0;
         rx_wr_q <= '0;
         rx_rd_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         tx_wr_q <= tx_wr_d;
         tx_rd_q <= tx_rd_d;
         rx_wr_q <= rx_wr_d;
         rx_rd_q <= rx_rd_d;
         ovf_q   <= ovf_d;
      end
   end

   // Burst sequencer with registered start pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         start_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!tx_empty && !rx_full && !bus.m_busy && !flush) begin
                  state_q <= START;
                  start_q <= 1'b1;
               end
            end
            START: begin
               state_q <= ACTIVE;
               start_q <= 1'b0;
            end
            ACTIVE: begin
               if (bus.m_done)
                  state_q <= HANDOFF;
               else if (!bus.m_busy)
                  state_q <= IDLE;
            end
            HANDOFF: state_q <= ACTIVE;
            default: begin
               state_q <= IDLE;
               start_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_fifo_bridge.sv
// Self-checking bench for spi_fifo_bridge: behavioural SPI master,
// host traffic, and a queue model of the expected RX word stream.
module tb_spi_fifo_bridge;
   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic clr_overflow = 1'b0;
   logic [3:0] tx_level, rx_level;
   logic rx_overflow;

   spi_fifo_bridge_if #(.DATA_WIDTH(DW)) bus();

   spi_fifo_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
      .clr_overflow(clr_overflow), .tx_level(tx_level),
      .rx_level(rx_level), .rx_overflow(rx_overflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // SPI master model state
   int ph = 0;
   int cnt = 0;
   logic [DW-1:0] word = '0;
   logic mst_busy = 1'b0;
   logic mst_done = 1'b0;
   logic [DW-1:0] mst_rx = '0;
   logic busy_force = 1'b0;
   logic rogue_req = 1'b0;
   logic rogue_done = 1'b0;
   logic [DW-1:0] resp_xor = '0;
   bit txe_log[$];

   int starts = 0;
   int start_full = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] rx_got[$];

   assign bus.m_busy    = mst_busy | busy_force;
   assign bus.m_done    = mst_done;
   assign bus.m_rx_data = mst_rx;

   // Behavioural SPI master: shifts a word for a few cycles, answers
   // with word ^ resp_xor, and decides continuation from m_txe.
   always begin : spi_master
      logic s_start, s_txe;
      logic [DW-1:0] s_head;
      @(negedge clk);
      s_start = bus.m_start;
      s_txe   = bus.m_txe;
      s_head  = bus.m_tx_data;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         ph = 0; mst_busy = 1'b0; mst_done = 1'b0;
      end else begin
         case (ph)
            0: if (s_start) begin
                  word = s_head; cnt = $urandom_range(2, 4);
                  mst_busy = 1'b1; ph = 1;
               end
            1: if (cnt == 0) begin
                  mst_done = 1'b1; mst_rx = word ^ resp_xor; ph = 2;
               end else cnt--;
            2: begin mst_done = 1'b0; ph = 3; end
            default: begin
               txe_log.push_back(s_txe);
               if (!s_txe || (rogue_req && !rogue_done)) begin
                  if (s_txe) rogue_done = 1'b1;
                  word = s_head; cnt = $urandom_range(2, 4); ph = 1;
               end else begin
                  mst_busy = 1'b0; ph = 0;
               end
            end
         endcase
      end
   end

   // Start-pulse monitor.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.m_start) starts++;
         if (bus.m_start && rx_level == 4'd8) start_full++;
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic push_word(input logic [DW-1:0] w, output bit ok);
      bus.wr_valid = 1'b1;
      bus.wr_data  = w;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         ok = bus.wr_ready;
         @(posedge clk);
         #1;
      end
      bus.wr_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      rx_got.delete();
      for (int i = 0; i < 5000 && rx_got.size() < n; i++) begin
         bus.rd_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (bus.rd_valid && bus.rd_ready) rx_got.push_back(bus.rd_data);
         @(posedge clk);
         #1;
      end
      bus.rd_ready = 1'b0;
   endtask

   task automatic settle();
      int k;
      for (k = 0; k < 500 && (bus.m_busy || tx_level != 0); k++) begin
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (bus.m_busy || tx_level != 0) begin
         n_bad++;
         $display("FAIL settle_timeout: busy=%0b tx_level=%0d required idle", bus.m_busy, tx_level);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [DW-1:0] got [8];
      logic [DW-1:0] req [8];
      string nm [8];
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      got[0] = DW'(tx_level);     req[0] = 0; nm[0] = "rst_tx_level";
      got[1] = DW'(rx_level);     req[1] = 0; nm[1] = "rst_rx_level";
      got[2] = DW'(bus.m_start);  req[2] = 0; nm[2] = "rst_m_start";
      got[3] = DW'(bus.m_txe);    req[3] = 1; nm[3] = "rst_m_txe";
      got[4] = DW'(bus.wr_ready); req[4] = 1; nm[4] = "rst_wr_ready";
      got[5] = DW'(bus.rd_valid); req[5] = 0; nm[5] = "rst_rd_valid";
      got[6] = bus.rd_data;       req[6] = 0; nm[6] = "rst_rd_data";
      got[7] = DW'(rx_overflow);  req[7] = 0; nm[7] = "rst_rx_overflow";
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (got[i] !== req[i]) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm[i], got[i], req[i]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      int s0, k;
      resp_xor = 32'hA5A5_0001 ^ 32'h0000_1234;
      s0 = starts;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'hA5A5_0001;
      @(posedge clk);
      #1 bus.wr_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (tx_level !== 4'd1 || bus.m_start !== 1'b0) begin
         n_bad++;
         $display("FAIL single_lvl1: tx_level=%0d m_start=%0b required 1/0", tx_level, bus.m_start);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.m_start !== 1'b1) begin
         n_bad++;
         $display("FAIL single_start: m_start=%0b required 1", bus.m_start);
      end
      @(negedge clk);
      n_cmp++;
      if (tx_level !== 4'd0 || bus.m_start !== 1'b0) begin
         n_bad++;
         $display("FAIL single_pop: tx_level=%0d m_start=%0b required 0/0", tx_level, bus.m_start);
      end
      for (k = 0; k < 50 && !bus.m_done; k++) @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h1234 || rx_level !== 4'd1) begin
         n_bad++;
         $display("FAIL single_rx: valid=%0b data=%0h level=%0d required 1/1234/1", bus.rd_valid, bus.rd_data, rx_level);
      end
      n_cmp++;
      if (starts - s0 !== 1) begin
         n_bad++;
         $display("FAIL single_starts: got %0d required 1", starts - s0);
      end
      @(posedge clk);
      #1 bus.rd_ready = 1'b1;
      @(posedge clk);
      #1 bus.rd_ready = 1'b0;
      n_cmp++;
      if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0) begin
         n_bad++;
         $display("FAIL single_empty: valid=%0b data=%0h required 0/0", bus.rd_valid, bus.rd_data);
      end
      settle();
   endtask

   task automatic test_burst();
      int s0, tb0, k;
      bit ok;
      logic [DW-1:0] w [3];
      w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
      resp_xor = $urandom;
      busy_force = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         push_word(w[i], ok);
         exp_q.push_back(w[i] ^ resp_xor);
      end
      n_cmp++;
      if (tx_level !== 4'd3) begin
         n_bad++;
         $display("FAIL burst_preload: tx_level=%0d required 3", tx_level);
      end
      s0 = starts;
      tb0 = txe_log.size();
      busy_force = 1'b0;
      @(posedge clk);
      #1;
      for (k = 0; k < 200 && (rx_level != 3 || bus.m_busy); k++) begin
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (starts - s0 !== 1 || txe_log.size() - tb0 !== 3) begin
         n_bad++;
         $display("FAIL burst_shape: starts=%0d handoffs=%0d required 1/3", starts - s0, txe_log.size() - tb0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (txe_log[tb0+i] !== (i == 2)) begin
               n_bad++;
               $display("FAIL burst_txe%0d: got %0b required %0b", i, txe_log[tb0+i], (i == 2));
            end
         end
      end
      drain(3);
      n_cmp++;
      if (rx_got.size() != 3) begin
         n_bad++;
         $display("FAIL burst_count: got %0d required 3", rx_got.size());
      end
      for (int i = 0; i < rx_got.size() && i < 3; i++) begin
         n_cmp++;
         if (rx_got[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL burst_word%0d: got %0h required %0h", i, rx_got[i], exp_q[i]);
         end
      end
      settle();
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         int n;
         logic [DW-1:0] w [$];
         resp_xor = $urandom;
         n = $urandom_range(5, 20);
         exp_q.delete();
         for (int i = 0; i < n; i++) begin
            w.push_back($urandom);
            exp_q.push_back(w[i] ^ resp_xor);
         end
         fork
            begin
               bit ok;
               for (int i = 0; i < n; i++) begin
                  repeat ($urandom_range(0, 3)) @(posedge clk);
                  #1;
                  push_word(w[i], ok);
                  n_cmp++;
                  if (!ok) begin
                     n_bad++;
                     $display("FAIL rand_push: word %0d not accepted", i);
                  end
               end
            end
            drain(n);
         join
         n_cmp++;
         if (rx_got.size() != n) begin
            n_bad++;
            $display("FAIL rand_count: got %0d required %0d", rx_got.size(), n);
         end
         for (int i = 0; i < rx_got.size() && i < n; i++) begin
            n_cmp++;
            if (rx_got[i] !== exp_q[i]) begin
               n_bad++;
               $display("FAIL rand_word%0d: got %0h required %0h", i, rx_got[i], exp_q[i]);
            end
         end
         settle();
      end
      n_cmp++;
      if (rx_overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL rand_ovf: got %0b required 0", rx_overflow);
      end
   endtask

   task automatic test_full_simul();
      int k;
      bit ok;
      logic [DW-1:0] w9;
      resp_xor = $urandom;
      exp_q.delete();
      busy_force = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [DW-1:0] w;
         w = $urandom;
         push_word(w, ok);
         exp_q.push_back(w ^ resp_xor);
      end
      n_cmp++;
      if (tx_level !== 4'd8) begin
         n_bad++;
         $display("FAIL full_level: got %0d required 8", tx_level);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.wr_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL full_wr_ready: got %0b required 0", bus.wr_ready);
      end
      w9 = $urandom;
      exp_q.push_back(w9 ^ resp_xor);
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = w9;
      busy_force   = 1'b0;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.m_start) break;
      end
      n_cmp++;
      if (bus.m_start !== 1'b1 || bus.wr_ready !== 1'b1 || tx_level !== 4'd8) begin
         n_bad++;
         $display("FAIL full_simul_pre: start=%0b wr_ready=%0b level=%0d required 1/1/8", bus.m_start, bus.wr_ready, tx_level);
      end
      @(posedge clk);
      #1 bus.wr_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (tx_level !== 4'd8) begin
         n_bad++;
         $display("FAIL full_simul_level: got %0d required 8", tx_level);
      end
      @(posedge clk);
      #1;
      drain(9);
      n_cmp++;
      if (rx_got.size() != 9) begin
         n_bad++;
         $display("FAIL full_count: got %0d required 9", rx_got.size());
      end
      for (int i = 0; i < rx_got.size() && i < 9; i++) begin
         n_cmp++;
         if (rx_got[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL full_word%0d: got %0h required %0h", i, rx_got[i], exp_q[i]);
         end
      end
      settle();
   endtask

   task automatic test_rx_stall();
      int sf, k;
      bit ok;
      resp_xor = $urandom;
      exp_q.delete();
      bus.rd_ready = 1'b0;
      sf = start_full;
      for (int i = 0; i < 10; i++) begin
         logic [DW-1:0] w;
         w = $urandom;
         push_word(w, ok);
         exp_q.push_back(w ^ resp_xor);
      end
      for (k = 0; k < 400 && (rx_level != 8 || bus.m_busy); k++) begin
         @(posedge clk);
         #1;
      end
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if (rx_level !== 4'd8 || tx_level !== 4'd2) begin
         n_bad++;
         $display("FAIL stall_levels: rx=%0d tx=%0d required 8/2", rx_level, tx_level);
      end
      n_cmp++;
      if (bus.m_txe !== 1'b1 || rx_overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_flags: txe=%0b ovf=%0b required 1/0", bus.m_txe, rx_overflow);
      end
      n_cmp++;
      if (start_full - sf !== 0) begin
         n_bad++;
         $display("FAIL stall_start_full: got %0d required 0", start_full - sf);
      end
      drain(10);
      n_cmp++;
      if (rx_got.size() != 10) begin
         n_bad++;
         $display("FAIL stall_count: got %0d required 10", rx_got.size());
      end
      for (int i = 0; i < rx_got.size() && i < 10; i++) begin
         n_cmp++;
         if (rx_got[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL stall_word%0d: got %0h required %0h", i, rx_got[i], exp_q[i]);
         end
      end
      settle();
   endtask

   task automatic test_flush();
      int s0, tb0, k;
      bit ok;
      logic [DW-1:0] first;
      resp_xor = $urandom;
      busy_force = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic [DW-1:0] w;
         w = $urandom;
         if (i == 0) first = w;
         push_word(w, ok);
      end
      s0 = starts;
      tb0 = txe_log.size();
      busy_force = 1'b0;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.m_start) break;
      end
      @(posedge clk);
      #1;
      flush = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = $urandom;
      @(negedge clk);
      n_cmp++;
      if (bus.wr_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_wr_ready: got %0b required 0", bus.wr_ready);
      end
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.wr_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (tx_level !== 4'd0) begin
         n_bad++;
         $display("FAIL flush_tx_level: got %0d required 0", tx_level);
      end
      for (k = 0; k < 50 && !bus.m_done; k++) @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (rx_level !== 4'd1) begin
         n_bad++;
         $display("FAIL flush_rx_level: got %0d required 1", rx_level);
      end
      repeat (12) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.m_busy !== 1'b0 || starts - s0 !== 1 || txe_log.size() - tb0 !== 1) begin
         n_bad++;
         $display("FAIL flush_end: busy=%0b starts=%0d handoffs=%0d required 0/1/1", bus.m_busy, starts - s0, txe_log.size() - tb0);
      end else begin
         n_cmp++;
         if (txe_log[tb0] !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_txe: got %0b required 1", txe_log[tb0]);
         end
      end
      drain(1);
      n_cmp++;
      if (rx_got.size() != 1 || rx_got[0] !== (first ^ resp_xor)) begin
         n_bad++;
         $display("FAIL flush_word: got %0h required %0h", rx_got.size() ? rx_got[0] : 32'h0, first ^ resp_xor);
      end
      settle();
   endtask

   task automatic test_overflow();
      int k;
      bit ok;
      resp_xor = $urandom;
      exp_q.delete();
      bus.rd_ready = 1'b0;
      busy_force = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [DW-1:0] w;
         w = $urandom;
         push_word(w, ok);
         exp_q.push_back(w ^ resp_xor);
      end
      rogue_req = 1'b1;
      busy_force = 1'b0;
      for (k = 0; k < 400 && !rx_overflow; k++) begin
         @(posedge clk);
         #1;
      end
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if (rx_overflow !== 1'b1 || rx_level !== 4'd8) begin
         n_bad++;
         $display("FAIL ovf_set: ovf=%0b rx_level=%0d required 1/8", rx_overflow, rx_level);
      end
      clr_overflow = 1'b1;
      @(posedge clk);
      #1 clr_overflow = 1'b0;
      n_cmp++;
      if (rx_overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_clear: got %0b required 0", rx_overflow);
      end
      drain(8);
      n_cmp++;
      if (rx_got.size() != 8) begin
         n_bad++;
         $display("FAIL ovf_count: got %0d required 8", rx_got.size());
      end
      for (int i = 0; i < rx_got.size() && i < 8; i++) begin
         n_cmp++;
         if (rx_got[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL ovf_word%0d: got %0h required %0h", i, rx_got[i], exp_q[i]);
         end
      end
      settle();
   endtask

   task automatic test_reset_midburst();
      int k;
      bit ok;
      resp_xor = $urandom;
      busy_force = 1'b1;
      for (int i = 0; i < 4; i++) push_word($urandom, ok);
      busy_force = 1'b0;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.m_start) break;
      end
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (tx_level !== 4'd0 || rx_level !== 4'd0) begin
         n_bad++;
         $display("FAIL rstmid_levels: tx=%0d rx=%0d required 0/0", tx_level, rx_level);
      end
      n_cmp++;
      if (bus.m_start !== 1'b0 || bus.m_txe !== 1'b1 || bus.rd_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_outs: start=%0b txe=%0b rd_valid=%0b required 0/1/0", bus.m_start, bus.m_txe, bus.rd_valid);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      settle();
      n_cmp++;
      if (rx_level !== 4'd0) begin
         n_bad++;
         $display("FAIL rstmid_after: rx_level=%0d required 0", rx_level);
      end
   endtask

   initial begin
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.rd_ready = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_random();
      test_full_simul();
      test_rx_stall();
      test_flush();
      test_overflow();
      test_reset_midburst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
